// File: rtl/datapath_p_if.sv
// Control-word and result bundle between the control unit, datapath_p and memory.
// The control unit drives the master side; the datapath implements the slave side.
interface datapath_p_if #(
    parameter int WIDTH  = 8,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
);
    logic                    RW;
    logic [ADDR_W-1:0]       DA;
    logic [ADDR_W-1:0]       AA;
    logic [ADDR_W-1:0]       BA;
    logic                    MB;
    logic                    MD;
    logic [3:0]              FS;
    logic [WIDTH-1:0]        Con_in;
    logic [WIDTH-1:0]        Datain;
    logic [WIDTH-1:0]        F;
    logic [WIDTH-1:0]        Address_out;
    logic [WIDTH-1:0]        Data_out;
    logic                    Z;
    logic                    N;
    logic                    C;
    logic                    V;
    logic [NREG*WIDTH-1:0]   R_flat;

    modport master (
        output RW, DA, AA, BA, MB, MD, FS, Con_in, Datain,
        input  F, Address_out, Data_out, Z, N, C, V, R_flat
    );

    modport slave (
        input  RW, DA, AA, BA, MB, MD, FS, Con_in, Datain,
        output F, Address_out, Data_out, Z, N, C, V, R_flat
    );
endinterface

// File: rtl/datapath_p.sv
// Pipelined register-file datapath: issue -> operand stage -> function unit -> writeback.
// Define DATAPATH_FWD_EN to forward in-flight writeback values to the operand stage.
module datapath_p #(
    parameter int WIDTH  = 8,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    datapath_p_if.slave bus
);

    logic [WIDTH-1:0]      rf_reg [NREG];
    logic [NREG*WIDTH-1:0] r_flat;

    // Operand stage (S1)
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [WIDTH-1:0]  a_next, b_next;
    logic [WIDTH-1:0]  rf_a, rf_b, b_src;
    logic              s1_rw_reg, s1_md_reg;
    logic [ADDR_W-1:0] s1_da_reg;
    logic [3:0]        s1_fs_reg;
    logic [WIDTH-1:0]  s1_din_reg;

    // Result stage (S2)
    logic [WIDTH-1:0]  g_reg;
    logic              z_reg, n_reg, c_reg, v_reg;
    logic              s2_rw_reg, s2_md_reg;
    logic [ADDR_W-1:0] s2_da_reg;
    logic [WIDTH-1:0]  s2_din_reg;
    logic [WIDTH-1:0]  wb_value;

    // Function unit
    logic [WIDTH-1:0]  y;
    logic              cin;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  alu_g;
    logic              alu_c, alu_v;

    assign rf_a     = rf_reg[bus.AA];
    assign rf_b     = rf_reg[bus.BA];
    assign wb_value = s2_md_reg ? s2_din_reg : g_reg;

`ifdef DATAPATH_FWD_EN
    logic [WIDTH-1:0] s1_wb;
    assign s1_wb = s1_md_reg ? s1_din_reg : alu_g;

    // The younger producer (S1) wins over S2 so the newest value is seen.
    always_comb begin
        a_next = rf_a;
        b_src  = rf_b;
        if (s1_rw_reg && (s1_da_reg == bus.AA)) begin
            a_next = s1_wb;
        end else if (s2_rw_reg && (s2_da_reg == bus.AA)) begin
            a_next = wb_value;
        end
        if (s1_rw_reg && (s1_da_reg == bus.BA)) begin
            b_src = s1_wb;
        end else if (s2_rw_reg && (s2_da_reg == bus.BA)) begin
            b_src = wb_value;
        end
    end
`else
    always_comb begin
        a_next = rf_a;
        b_src  = rf_b;
    end
`endif

    assign b_next = bus.MB ? bus.Con_in : b_src;

    // All arithmetic codes share one W+1-bit adder: A + y + cin.
    always_comb begin
        y   = '0;
        cin = 1'b0;
        case (s1_fs_reg)
            4'b0001: cin = 1'b1;
            4'b0010: y = b_reg;
            4'b0011: begin y = b_reg;  cin = 1'b1; end
            4'b0100: y = ~b_reg;
            4'b0101: begin y = ~b_reg; cin = 1'b1; end
            4'b0110: y = '1;
            default: ;
        endcase
        sum = {1'b0, a_reg} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

        alu_g = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (s1_fs_reg)
            4'b0000, 4'b0111: alu_g = a_reg;
            4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110: begin
                alu_g = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a_reg[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
            end
            4'b1000: alu_g = a_reg & b_reg;
            4'b1001: alu_g = a_reg | b_reg;
            4'b1010: alu_g = a_reg ^ b_reg;
            4'b1011: alu_g = ~a_reg;
            4'b1100: alu_g = b_reg;
            4'b1101: begin alu_g = {b_reg[WIDTH-2:0], 1'b0}; alu_c = b_reg[WIDTH-1]; end
            4'b1110: begin alu_g = {1'b0, b_reg[WIDTH-1:1]}; alu_c = b_reg[0]; end
            default: alu_g = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            s1_rw_reg  <= 1'b0;
            s1_md_reg  <= 1'b0;
            s1_da_reg  <= '0;
            s1_fs_reg  <= '0;
            s1_din_reg <= '0;
            g_reg      <= '0;
            z_reg      <= 1'b1;
            n_reg      <= 1'b0;
            c_reg      <= 1'b0;
            v_reg      <= 1'b0;
            s2_rw_reg  <= 1'b0;
            s2_md_reg  <= 1'b0;
            s2_da_reg  <= '0;
            s2_din_reg <= '0;
        end else begin
            a_reg      <= a_next;
            b_reg      <= b_next;
            s1_rw_reg  <= bus.RW;
            s1_md_reg  <= bus.MD;
            s1_da_reg  <= bus.DA;
            s1_fs_reg  <= bus.FS;
            s1_din_reg <= bus.Datain;
            g_reg      <= alu_g;
            z_reg      <= (alu_g == '0);
            n_reg      <= alu_g[WIDTH-1];
            c_reg      <= alu_c;
            v_reg      <= alu_v;
            s2_rw_reg  <= s1_rw_reg;
            s2_md_reg  <= s1_md_reg;
            s2_da_reg  <= s1_da_reg;
            s2_din_reg <= s1_din_reg;
        end
    end

    // Reset also drops whatever write was still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (s2_rw_reg) begin
            rf_reg[s2_da_reg] <= wb_value;
        end
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
            assign r_flat[gi*WIDTH +: WIDTH] = rf_reg[gi];
        end
    endgenerate

    assign bus.R_flat      = r_flat;
    assign bus.F           = g_reg;
    assign bus.Address_out = a_reg;
    assign bus.Data_out    = b_reg;
    assign bus.Z           = z_reg;
    assign bus.N           = n_reg;
    assign bus.C           = c_reg;
    assign bus.V           = v_reg;

endmodule

// File: tb/tb_datapath_p.sv
// Bench for datapath_p: reset, flag/shift vector table, load-add, hazard, mid-pipeline reset,
// 16-bit parameter sweep, then random issues against an architectural reference model.
module tb_datapath_p;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    datapath_p_if #(.WIDTH(8),  .NREG(8),  .ADDR_W(3)) bus8 ();
    datapath_p_if #(.WIDTH(16), .NREG(16), .ADDR_W(4)) bus16 ();

    datapath_p #(.WIDTH(8), .NREG(8), .ADDR_W(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    datapath_p #(.WIDTH(16), .NREG(16), .ADDR_W(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

`ifdef DATAPATH_FWD_EN
    localparam int LAG     = 1;
    localparam int HAZ_EXP = 8;
`else
    localparam int LAG     = 3;
    localparam int HAZ_EXP = 6;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] fs;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] f;
        logic       z, n, c, v;
    } vec_t;

    vec_t vt [13];

    // Architectural register state after each issue, ring of the last four.
    int st [4][8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set8(input logic rw, input logic [2:0] da, input logic [2:0] aa,
                        input logic [2:0] ba, input logic mb, input logic md,
                        input logic [3:0] fs, input logic [7:0] con, input logic [7:0] din);
        bus8.RW = rw; bus8.DA = da; bus8.AA = aa; bus8.BA = ba;
        bus8.MB = mb; bus8.MD = md; bus8.FS = fs; bus8.Con_in = con; bus8.Datain = din;
    endtask

    task automatic set16(input logic rw, input logic [3:0] da, input logic [3:0] aa,
                         input logic md, input logic [3:0] fs, input logic [15:0] din);
        bus16.RW = rw; bus16.DA = da; bus16.AA = aa; bus16.BA = 4'd0;
        bus16.MB = 1'b0; bus16.MD = md; bus16.FS = fs; bus16.Con_in = '0; bus16.Datain = din;
    endtask

    task automatic issue8(input logic rw, input logic [2:0] da, input logic [2:0] aa,
                          input logic [2:0] ba, input logic mb, input logic md,
                          input logic [3:0] fs, input logic [7:0] con, input logic [7:0] din);
        set8(rw, da, aa, ba, mb, md, fs, con, din);
        tick();
    endtask

    task automatic nop8();
        issue8(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
    endtask

    // Reference function unit: plain unsigned / signed integer arithmetic on 8 bits.
    function automatic void m_alu(input logic [3:0] fs, input int a, input int b,
                                  output int g, output logic c, output logic v);
        int sa, sb, sv;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        sv = 0;
        c  = 1'b0;
        v  = 1'b0;
        g  = 0;
        case (fs)
            4'd0, 4'd7: g = a;
            4'd1: begin g = (a + 1) & 255;       c = (a + 1) > 255;       sv = sa + 1;      end
            4'd2: begin g = (a + b) & 255;       c = (a + b) > 255;       sv = sa + sb;     end
            4'd3: begin g = (a + b + 1) & 255;   c = (a + b + 1) > 255;   sv = sa + sb + 1; end
            4'd4: begin g = (a - b - 1) & 255;   c = a > b;               sv = sa - sb - 1; end
            4'd5: begin g = (a - b) & 255;       c = a >= b;              sv = sa - sb;     end
            4'd6: begin g = (a - 1) & 255;       c = a != 0;              sv = sa - 1;      end
            4'd8:  g = a & b;
            4'd9:  g = a | b;
            4'd10: g = a ^ b;
            4'd11: g = 255 - a;
            4'd12: g = b;
            4'd13: begin g = (b * 2) & 255; c = b >= 128; end
            4'd14: begin g = b / 2;         c = (b % 2) == 1; end
            default: g = 0;
        endcase
        if (fs >= 4'd1 && fs <= 4'd6) v = (sv > 127) || (sv < -128);
    endfunction

    initial begin
        set8(1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 4'd0, 8'd0, 8'h55);
        set16(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 16'h1234);

        vt[0]  = '{4'b0001, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[1]  = '{4'b0001, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{4'b0101, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{4'b0101, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{4'b1101, 8'h00, 8'h81, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{4'b1110, 8'h00, 8'h81, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{4'b1111, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{4'b0010, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{4'b1000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{4'b1011, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{4'b0110, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[11] = '{4'b0100, 8'h05, 8'h03, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[12] = '{4'b0011, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset with a write-carrying word at the reset edge: it must be discarded.
        tick();
        rst = 1'b0;
        set16(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'd0);
        chk("rst_F", bus8.F, 64'h0);
        chk("rst_flags", {bus8.Z, bus8.N, bus8.C, bus8.V}, 64'b1000);
        chk("rst_addr_data", {bus8.Address_out, bus8.Data_out}, 64'h0);
        chk("rst_rflat", bus8.R_flat, 64'h0);
        nop8(); nop8(); nop8();
        chk("rst_issue_nowrite", bus8.R_flat, 64'h0);
        chk("rst_hold_flags", {bus8.F, bus8.Z, bus8.N, bus8.C, bus8.V}, {8'h00, 4'b1000});
        $display("[TB] reset sequence done");

        // Vector table: load A into R1, then operate with B from Con_in.
        for (int i = 0; i < 13; i++) begin
            issue8(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 4'd0, 8'd0, vt[i].a);
            nop8(); nop8();
            issue8(1'b0, 3'd0, 3'd1, 3'd0, 1'b1, 1'b0, vt[i].fs, vt[i].b, 8'd0);
            chk($sformatf("vec%0d_addr", i), bus8.Address_out, vt[i].a);
            chk($sformatf("vec%0d_data", i), bus8.Data_out, vt[i].b);
            nop8();
            chk($sformatf("vec%0d_F", i), bus8.F, vt[i].f);
            chk($sformatf("vec%0d_flags", i), {bus8.Z, bus8.N, bus8.C, bus8.V},
                {vt[i].z, vt[i].n, vt[i].c, vt[i].v});
            $display("[TB] vec %0d fs=%b a=%h b=%h F=%h", i, vt[i].fs, vt[i].a, vt[i].b, bus8.F);
        end

        // Load-and-add: R1=5, R2=3, R3 <- R1+R2.
        issue8(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 4'd0, 8'd0, 8'd5);
        issue8(1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 4'd0, 8'd0, 8'd3);
        nop8(); nop8();
        issue8(1'b1, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 4'b0010, 8'd0, 8'd0);
        nop8();
        chk("add_F", bus8.F, 64'h08);
        chk("add_CV", {bus8.C, bus8.V}, 64'b00);
        chk("add_R3_before", bus8.R_flat[31:24], 64'h00);
        nop8();
        chk("add_R3", bus8.R_flat[31:24], 64'h08);
        $display("[TB] load-add R3=%h", bus8.R_flat[31:24]);

        // Hazard: three back-to-back R1 <- R1+1 starting from R1=5.
        issue8(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 4'd0, 8'd0, 8'd5);
        nop8(); nop8();
        for (int k = 0; k < 3; k++) issue8(1'b1, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 4'b0001, 8'd0, 8'd0);
        nop8(); nop8();
        chk("hazard_R1", bus8.R_flat[15:8], HAZ_EXP);
        $display("[TB] hazard R1=%0d", bus8.R_flat[15:8]);

        // Mid-pipeline reset cancels a write still in flight.
        issue8(1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 4'd0, 8'd0, 8'h33);
        rst = 1'b1;
        nop8();
        rst = 1'b0;
        nop8(); nop8(); nop8();
        chk("midrst_rflat", bus8.R_flat, 64'h0);
        chk("midrst_F_Z", {bus8.F, bus8.Z}, {8'h00, 1'b1});
        $display("[TB] mid-pipeline reset done");

        // 16-bit / 16-register sweep.
        set16(1'b1, 4'd15, 4'd0, 1'b1, 4'd0, 16'hFFFF);
        tick();
        set16(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'd0);
        tick(); tick();
        set16(1'b0, 4'd0, 4'd15, 1'b0, 4'b0001, 16'd0);
        tick();
        set16(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'd0);
        tick();
        chk("w16_F", bus16.F, 64'h0);
        chk("w16_flags", {bus16.Z, bus16.N, bus16.C, bus16.V}, 64'b1010);
        chk("w16_R15", bus16.R_flat[255:240], 64'hFFFF);
        chk("w16_low", bus16.R_flat[239:176], 64'h0);
        $display("[TB] sweep16 R15=%h F=%h", bus16.R_flat[255:240], bus16.F);

        // Random issues against the architectural model.
        rst = 1'b1;
        nop8();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) for (int r = 0; r < 8; r++) st[s][r] = 0;
        begin
            int pg;
            logic pz, pn, pc, pv;
            pg = 0; pz = 1'b1; pn = 1'b0; pc = 1'b0; pv = 1'b0;
            for (int t = 0; t < 300; t++) begin
                logic       rw, mb, md, c, v;
                logic [2:0] da, aa, ba;
                logic [3:0] fs;
                logic [7:0] con, din;
                logic [63:0] exp_flat;
                int a, b, g, src, cur, prv, old;
                rw  = ($urandom_range(0, 3) != 0);
                mb  = $urandom_range(0, 1);
                md  = ($urandom_range(0, 3) == 0);
                da  = 3'($urandom_range(0, 7));
                aa  = 3'($urandom_range(0, 7));
                ba  = 3'($urandom_range(0, 7));
                fs  = 4'($urandom_range(0, 15));
                con = 8'($urandom_range(0, 255));
                din = 8'($urandom_range(0, 255));
                src = (t - LAG) & 3;
                cur = t & 3;
                prv = (t - 1) & 3;
                old = (t - 2) & 3;
                a = st[src][aa];
                b = mb ? int'(con) : st[src][ba];
                m_alu(fs, a, b, g, c, v);
                for (int r = 0; r < 8; r++) st[cur][r] = st[prv][r];
                if (rw) st[cur][da] = md ? int'(din) : g;
                issue8(rw, da, aa, ba, mb, md, fs, con, din);
                exp_flat = '0;
                for (int r = 0; r < 8; r++) exp_flat[r*8 +: 8] = 8'(st[old][r]);
                chk("rnd_addr", bus8.Address_out, 64'(a));
                chk("rnd_data", bus8.Data_out, 64'(b));
                chk("rnd_F", bus8.F, 64'(pg));
                chk("rnd_flags", {bus8.Z, bus8.N, bus8.C, bus8.V}, {pz, pn, pc, pv});
                chk("rnd_rflat", bus8.R_flat, exp_flat);
                $display("[TB] rnd t=%0d fs=%h a=%h b=%h F=%h", t, fs, a[7:0], b[7:0], bus8.F);
                pg = g;
                pz = (g == 0);
                pn = (g >= 128);
                pc = c;
                pv = v;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
